// File: rtl/gray_step_decoder.sv
// Gray-code step decoder: converts sampled Gray words to binary and classifies each step (+1/-1/hold/jump), with lock tracking.
// Latency: 1 cycle, sample at edge N appears on the registered outputs after edge N.
// Backpressure: none, every gray_valid cycle is accepted.
module gray_step_decoder #(
  parameter int WIDTH     = 4,
  parameter int ERR_LIMIT = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             gray_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step_up,
  output logic             step_down,
  output logic             step_hold,
  output logic             step_err,
  output logic             locked,
  output logic [CNT_W-1:0] err_count
);

  localparam int CW = (ERR_LIMIT < 1) ? 1 : $clog2(ERR_LIMIT + 1);

  typedef enum logic {
    UNLOCK = 1'b0,
    LOCK   = 1'b1
  } state_t;

  typedef struct packed {
    logic up;
    logic down;
    logic hold;
    logic err;
  } step_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             bv_q, bv_d;
  step_t            flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]    consec_q, consec_d;

  logic [WIDTH-1:0] bin_c;
  logic [WIDTH-1:0] diff;
  step_t            cls;
  logic             limit_hit;

  // Binary bit i is the XOR of all Gray bits from i upward.
  for (genvar i = 0; i < WIDTH; i++) begin : g_conv
    assign bin_c[i] = ^(gray_in >> i);
  end

  // bin_q doubles as the previous accepted sample.
  assign diff = bin_c - bin_q;

  always_comb begin
    cls      = '0;
    cls.up   = (diff == WIDTH'(1));
    cls.down = (diff == {WIDTH{1'b1}});
    cls.hold = (diff == '0);
    cls.err  = !(cls.up || cls.down || cls.hold);
  end

  assign limit_hit = (consec_q == CW'(ERR_LIMIT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= UNLOCK;
      bin_q    <= '0;
      bv_q     <= 1'b0;
      flags_q  <= '0;
      cnt_q    <= '0;
      consec_q <= '0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bv_q     <= bv_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
      consec_q <= consec_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (gray_valid) begin
      case (state_q)
        UNLOCK:  state_d = LOCK;
        LOCK:    if (cls.err && limit_hit) state_d = UNLOCK;
        default: state_d = UNLOCK;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    bv_d     = gray_valid;
    bin_d    = bin_q;
    flags_d  = flags_q;
    cnt_d    = cnt_q;
    consec_d = consec_q;
    if (gray_valid) begin
      bin_d = bin_c;
      if (state_q == UNLOCK) begin
        // Seeding sample: no previous value to compare against.
        flags_d  = '0;
        consec_d = '0;
      end else begin
        flags_d = cls;
        if (cls.err) begin
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
          consec_d = limit_hit ? '0 : consec_q + 1'b1;
        end else begin
          consec_d = '0;
        end
      end
    end
  end

  assign bin_out   = bin_q;
  assign bin_valid = bv_q;
  assign step_up   = flags_q.up;
  assign step_down = flags_q.down;
  assign step_hold = flags_q.hold;
  assign step_err  = flags_q.err;
  assign locked    = (state_q == LOCK);
  assign err_count = cnt_q;

endmodule

// File: tb/tb_gray_step_decoder.sv
// Directed-vector bench for gray_step_decoder (WIDTH=4, ERR_LIMIT=2, CNT_W=8).
module tb_gray_step_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] gray_in;
  logic       gray_valid;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic       step_up, step_down, step_hold, step_err, locked;
  logic [7:0] err_count;

  int n_vec = 0;
  int n_bad = 0;

  gray_step_decoder #(.WIDTH(4), .ERR_LIMIT(2), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .gray_in   (gray_in),
    .gray_valid(gray_valid),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .step_up   (step_up),
    .step_down (step_down),
    .step_hold (step_hold),
    .step_err  (step_err),
    .locked    (locked),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // flags = {up, down, hold, err}
  typedef struct {
    logic       rst;
    logic       vld;
    logic [3:0] g;
    logic [3:0] bin;
    logic       bv;
    logic [3:0] flags;
    logic       lk;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic vld, input logic [3:0] g,
                     input logic [3:0] bin, input logic bv, input logic [3:0] flags,
                     input logic lk, input logic [7:0] cnt);
    vec_t v;
    v.rst = rst; v.vld = vld; v.g = g; v.bin = bin; v.bv = bv;
    v.flags = flags; v.lk = lk; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic vld, input logic [3:0] g);
    reset = rst; gray_valid = vld; gray_in = g;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    logic [3:0] cur;
    int exp_cnt;
    reset = 1'b1; gray_valid = 1'b0; gray_in = 4'h0;

    // rst vld gray     bin   bv flags(udhe) lk cnt
    add(1, 0, 4'b0000, 4'd0,  0, 4'b0000, 0, 0);   // reset state
    add(0, 1, 4'b0000, 4'd0,  1, 4'b0000, 1, 0);   // seed
    add(0, 1, 4'b0001, 4'd1,  1, 4'b1000, 1, 0);
    add(0, 1, 4'b0011, 4'd2,  1, 4'b1000, 1, 0);
    add(0, 1, 4'b0010, 4'd3,  1, 4'b1000, 1, 0);
    add(0, 0, 4'b1111, 4'd3,  0, 4'b1000, 1, 0);   // idle: outputs hold
    add(1, 0, 4'b0000, 4'd0,  0, 4'b0000, 0, 0);
    add(0, 1, 4'b1000, 4'd15, 1, 4'b0000, 1, 0);   // seed at max
    add(0, 1, 4'b0000, 4'd0,  1, 4'b1000, 1, 0);   // 15 -> 0 up
    add(0, 1, 4'b1000, 4'd15, 1, 4'b0100, 1, 0);   // 0 -> 15 down
    add(1, 0, 4'b0000, 4'd0,  0, 4'b0000, 0, 0);
    add(0, 1, 4'b0011, 4'd2,  1, 4'b0000, 1, 0);
    add(0, 1, 4'b0011, 4'd2,  1, 4'b0010, 1, 0);   // hold
    add(0, 1, 4'b0001, 4'd1,  1, 4'b0100, 1, 0);   // down
    add(0, 1, 4'b0001, 4'd1,  1, 4'b0010, 1, 0);
    add(0, 1, 4'b0110, 4'd4,  1, 4'b0001, 1, 1);   // single illegal jump
    add(0, 1, 4'b0111, 4'd5,  1, 4'b1000, 1, 1);   // recovers
    add(1, 0, 4'b0000, 4'd0,  0, 4'b0000, 0, 0);
    add(0, 1, 4'b0001, 4'd1,  1, 4'b0000, 1, 0);
    add(0, 1, 4'b0110, 4'd4,  1, 4'b0001, 1, 1);
    add(0, 1, 4'b1111, 4'd10, 1, 4'b0001, 0, 2);   // second in a row: unlock
    add(0, 1, 4'b1110, 4'd11, 1, 4'b0000, 1, 2);   // re-seed, no check
    add(0, 1, 4'b1010, 4'd12, 1, 4'b1000, 1, 2);
    add(1, 1, 4'b0000, 4'd0,  0, 4'b0000, 0, 0);   // reset beats valid
    add(0, 1, 4'b0011, 4'd2,  1, 4'b0000, 1, 0);
    add(0, 0, 4'b0000, 4'd2,  0, 4'b0000, 1, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].g);
      chk("bin_out",   i, {4'h0, bin_out},   {4'h0, tbl[i].bin});
      chk("bin_valid", i, {7'h0, bin_valid}, {7'h0, tbl[i].bv});
      chk("flags",     i, {4'h0, step_up, step_down, step_hold, step_err}, {4'h0, tbl[i].flags});
      chk("locked",    i, {7'h0, locked},    {7'h0, tbl[i].lk});
      chk("err_count", i, err_count,         tbl[i].cnt);
    end

    // Saturation: isolated errors separated by legal +1 steps keep lock held.
    cur = 4'd2;
    for (int k = 1; k <= 260; k++) begin
      drive(1'b0, 1'b1, b2g(cur + 4'd4));
      exp_cnt = (k > 255) ? 255 : k;
      chk("sat_err",   k, {7'h0, step_err}, 8'h01);
      chk("sat_count", k, err_count, 8'(exp_cnt));
      drive(1'b0, 1'b1, b2g(cur + 4'd5));
      chk("sat_up",    k, {7'h0, step_up}, 8'h01);
      cur = cur + 4'd5;
    end
    drive(1'b0, 1'b0, 4'h0);
    chk("sat_final", 0, err_count, 8'd255);
    chk("sat_lock",  0, {7'h0, locked}, 8'h01);
    chk("sat_bv",    0, {7'h0, bin_valid}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
